// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: stores deframed bytes in a circular RAM and commits whole
// FCS-good frames (FCS stripped) into a length queue for a valid/ready consumer.
module rx_frame_buffer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 2
) (
  input  logic              netclk,
  input  logic              reset_n,
  input  logic              byte_ready,
  input  logic [7:0]        din,
  input  logic              frame_complete,
  input  logic              frame_valid,
  input  logic              frame_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_len,
  output logic              err_crc,
  output logic              err_abort,
  output logic              err_ovf
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LDEPTH = 1 << LEN_W;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_ram [DEPTH];
  logic [ADDR_W-1:0]   r_lf_mem [LDEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr, r_cnt, r_cons;
  logic [LEN_W-1:0]    r_lf_wr, r_lf_rd;
  logic [LEN_W:0]      r_lf_cnt;
  logic [7:0]          r_rd_data;
  logic                r_br_q, r_fc_q, r_fa_q;
  logic                r_err_crc, r_err_abort, r_err_ovf;

  logic                w_br_rise, w_fc_rise, w_fa_rise, w_end;
  logic                w_full, w_byte_ok, w_byte_lost;
  logic [ADDR_W-1:0]   w_wr_inc, w_wr_after, w_cnt_after, w_len;
  logic [ADDR_W-1:0]   w_wr_ptr_nxt, w_commit_nxt, w_cnt_nxt;
  logic                w_wr_en, w_push, w_crc, w_abort, w_ovf;
  logic                w_lf_full, w_lf_empty, w_xfer, w_pop;
  logic [ADDR_W-1:0]   w_head_len, w_rem, w_rd_addr;

  assign w_br_rise   = byte_ready & ~r_br_q;
  assign w_fc_rise   = frame_complete & ~r_fc_q;
  assign w_fa_rise   = frame_abort & ~r_fa_q;
  assign w_end       = w_fc_rise | w_fa_rise;

  // One slot is always left empty so the writer can never land on unread data.
  assign w_wr_inc    = r_wr_ptr + ADDR_W'(1);
  assign w_full      = (w_wr_inc == r_rd_ptr);
  assign w_byte_ok   = w_br_rise & ~w_full;
  assign w_byte_lost = w_br_rise & w_full;
  assign w_wr_after  = w_byte_ok ? w_wr_inc : r_wr_ptr;
  assign w_cnt_after = w_byte_ok ? r_cnt + ADDR_W'(1) : r_cnt;
  assign w_len       = w_cnt_after - ADDR_W'(2);

  assign w_lf_empty  = (r_lf_cnt == '0);
  assign w_lf_full   = (r_lf_cnt == (LEN_W+1)'(LDEPTH));

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_cnt_nxt    = r_cnt;
    w_push       = 1'b0;
    w_crc        = 1'b0;
    w_abort      = 1'b0;
    w_ovf        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_br_rise) begin
          if (w_full) begin
            w_state_nxt = DROP;
          end else begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = w_wr_inc;
            w_cnt_nxt    = ADDR_W'(1);
            w_state_nxt  = RECV;
          end
        end
      end
      RECV: begin
        // A byte arriving with the end event is counted before the end is judged.
        w_wr_en      = w_byte_ok;
        w_wr_ptr_nxt = w_wr_after;
        w_cnt_nxt    = w_cnt_after;
        if (w_end) begin
          w_state_nxt  = IDLE;
          w_wr_ptr_nxt = r_commit_ptr;
          if (w_byte_lost)                                        w_ovf   = 1'b1;
          else if (w_fa_rise)                                     w_abort = 1'b1;
          else if (!frame_valid || w_cnt_after < ADDR_W'(3))      w_crc   = 1'b1;
          else if (w_lf_full)                                     w_ovf   = 1'b1;
          else begin
            w_push       = 1'b1;
            w_wr_ptr_nxt = w_wr_after - ADDR_W'(2);
            w_commit_nxt = w_wr_after - ADDR_W'(2);
          end
        end else if (w_byte_lost) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (w_end) begin
          w_state_nxt  = IDLE;
          w_wr_ptr_nxt = r_commit_ptr;
          w_ovf        = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_valid  = ~w_lf_empty;
  assign w_head_len = r_lf_mem[r_lf_rd];
  assign w_rem      = w_head_len - r_cons;
  assign out_last   = out_valid & (w_rem == ADDR_W'(1));
  assign out_len    = out_valid ? w_head_len : '0;
  assign out_data   = out_valid ? r_rd_data : '0;
  assign w_xfer     = out_valid & out_ready;
  assign w_pop      = w_xfer & out_last;
  // Prefetch the byte that will sit at rd_ptr after this edge.
  assign w_rd_addr  = w_xfer ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;

  assign err_crc    = r_err_crc;
  assign err_abort  = r_err_abort;
  assign err_ovf    = r_err_ovf;

  always_ff @(posedge netclk) begin
    if (reset_n && w_wr_en) r_ram[r_wr_ptr] <= din;
  end

  always_ff @(posedge netclk) begin
    if (reset_n && w_push) r_lf_mem[r_lf_wr] <= w_len;
  end

  always_ff @(posedge netclk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_br_q       <= 1'b0;
      r_fc_q       <= 1'b0;
      r_fa_q       <= 1'b0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_cons       <= '0;
      r_lf_wr      <= '0;
      r_lf_rd      <= '0;
      r_lf_cnt     <= '0;
      r_rd_data    <= '0;
      r_err_crc    <= 1'b0;
      r_err_abort  <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_br_q       <= byte_ready;
      r_fc_q       <= frame_complete;
      r_fa_q       <= frame_abort;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err_crc    <= w_crc;
      r_err_abort  <= w_abort;
      r_err_ovf    <= w_ovf;
      r_rd_data    <= r_ram[w_rd_addr];
      if (w_push) r_lf_wr <= r_lf_wr + LEN_W'(1);
      if (w_pop)  r_lf_rd <= r_lf_rd + LEN_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_lf_cnt <= r_lf_cnt + (LEN_W+1)'(1);
        2'b01:   r_lf_cnt <= r_lf_cnt - (LEN_W+1)'(1);
        default: r_lf_cnt <= r_lf_cnt;
      endcase
      if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        r_cons   <= w_pop ? '0 : r_cons + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed plus randomized frames against a queue-based model of committed payload,
// with a negedge monitor checking the output stream and counting error pulses.
module tb_rx_frame_buffer;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 2;
  localparam int CAP    = (1 << ADDR_W) - 1;
  localparam int LCAP   = 1 << LEN_W;

  logic              netclk = 1'b0;
  logic              reset_n = 1'b0;
  logic              byte_ready = 1'b0;
  logic [7:0]        din = 8'h00;
  logic              frame_complete = 1'b0;
  logic              frame_valid = 1'b0;
  logic              frame_abort = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic [ADDR_W-1:0] out_len;
  logic              err_crc, err_abort, err_ovf;

  always #5 netclk = ~netclk;

  rx_frame_buffer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .netclk(netclk), .reset_n(reset_n), .byte_ready(byte_ready), .din(din),
    .frame_complete(frame_complete), .frame_valid(frame_valid), .frame_abort(frame_abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_len(out_len), .err_crc(err_crc), .err_abort(err_abort), .err_ovf(err_ovf)
  );

  typedef struct { logic [7:0] data; logic last; int len; } exp_t;
  exp_t       exp_q[$];
  int         checks = 0, errors = 0;
  int         n_xfer = 0, n_crc = 0, n_abt = 0, n_ovf = 0;
  logic [7:0] fbuf [0:299];
  bit         rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int q_frames();
    int c = 0;
    foreach (exp_q[i]) if (exp_q[i].last) c++;
    return c;
  endfunction

  always @(negedge netclk) begin : mon
    exp_t e;
    if (err_crc)   n_crc++;
    if (err_abort) n_abt++;
    if (err_ovf)   n_ovf++;
    if (reset_n && out_valid && out_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) chk("extra_byte", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
        chk("out_len", out_len, e.len);
      end
    end
  end

  task automatic tick();
    @(posedge netclk); #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) fbuf[i] = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    byte_ready = 1'b1; din = b;
    repeat (hold) tick();
    byte_ready = 1'b0;
    tick();
  endtask

  // kind: 0 complete/FCS good, 1 complete/FCS bad, 2 abort, 3 complete+abort together.
  // same: last byte rises in the same cycle as the end event.
  task automatic send_frame(input int n, input int hold, input int kind, input bit same);
    int   c0, a0, o0, outcome;
    exp_t e;
    if (n > CAP - exp_q.size())        outcome = 3;
    else if (kind >= 2)                outcome = 2;
    else if (kind == 1 || n < 3)       outcome = 1;
    else if (q_frames() == LCAP)       outcome = 3;
    else                               outcome = 0;
    c0 = n_crc; a0 = n_abt; o0 = n_ovf;
    for (int i = 0; i < n; i++)
      if (!(same && i == n - 1)) send_byte(fbuf[i], hold);
    if (outcome == 0)
      for (int i = 0; i < n - 2; i++) begin
        e.data = fbuf[i]; e.last = (i == n - 3); e.len = n - 2;
        exp_q.push_back(e);
      end
    if (same) begin byte_ready = 1'b1; din = fbuf[n-1]; end
    frame_valid    = (kind == 0);
    frame_complete = (kind != 2);
    frame_abort    = (kind >= 2);
    tick(); tick();
    byte_ready = 1'b0; frame_complete = 1'b0; frame_abort = 1'b0; frame_valid = 1'b0;
    tick(); tick();
    chk("err_crc_pulses",   n_crc - c0, (outcome == 1) ? 1 : 0);
    chk("err_abort_pulses", n_abt - a0, (outcome == 2) ? 1 : 0);
    chk("err_ovf_pulses",   n_ovf - o0, (outcome == 3) ? 1 : 0);
  endtask

  task automatic drain(input bit rnd);
    int guard = 0;
    if (rnd) rnd_rdy = 1'b1; else out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 3000) begin tick(); guard++; end
    chk("drain_complete", exp_q.size(), 0);
    exp_q.delete();
    rnd_rdy = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    int x0, c0, a0, o0, nfr, goods, kind, n;
    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_len",   out_len, 0);
    chk("rst_err", {err_crc, err_abort, err_ovf}, 0);
    reset_n = 1'b1;
    tick();

    // Basic good frame, hold while not ready
    fbuf[0] = 8'h11; fbuf[1] = 8'h22; fbuf[2] = 8'h33; fbuf[3] = 8'hA5; fbuf[4] = 8'h5A;
    send_frame(5, 1, 0, 0);
    chk("good_valid", out_valid, 1);
    chk("good_len", out_len, 3);
    chk("good_first", out_data, 8'h11);
    chk("good_last_early", out_last, 0);
    repeat (3) tick();
    chk("hold_data", out_data, 8'h11);
    drain(0);

    // Bad FCS, abort, then a clean frame
    send_frame(5, 1, 1, 0);
    chk("crc_no_valid", out_valid, 0);
    fill_rand(3);
    send_frame(3, 1, 2, 0);
    chk("abort_no_valid", out_valid, 0);
    fill_rand(6);
    send_frame(6, 1, 0, 0);
    drain(0);

    // Same-cycle byte/end, abort beats complete, too-short frame
    fill_rand(5); send_frame(5, 2, 0, 1);
    fill_rand(4); send_frame(4, 1, 3, 1);
    fill_rand(2); send_frame(2, 1, 0, 0);
    fill_rand(3); send_frame(3, 1, 0, 1);
    drain(0);

    // Long strobes, RAM capacity boundaries
    fill_rand(7);   send_frame(7, 3, 0, 0); drain(0);
    fill_rand(260); send_frame(260, 1, 0, 0);
    chk("ovf_no_valid", out_valid, 0);
    fill_rand(255); send_frame(255, 1, 0, 0);
    chk("max_len", out_len, 253);
    drain(1);
    fill_rand(256); send_frame(256, 1, 0, 0);
    fill_rand(5);   send_frame(5, 1, 0, 0); drain(0);

    // Length queue full, then back-to-back drain
    for (int k = 0; k < 5; k++) begin fill_rand(4); send_frame(4, 1, 0, 0); end
    out_ready = 1'b1;
    x0 = n_xfer;
    repeat (8) tick();
    chk("no_bubble_xfers", n_xfer - x0, 8);
    chk("lfifo_drained", exp_q.size(), 0);
    out_ready = 1'b0;
    tick();
    chk("lfifo_empty_valid", out_valid, 0);

    // Randomized batches with concurrent reading
    for (int b = 0; b < 6; b++) begin
      rnd_rdy = 1'b1;
      nfr = $urandom_range(1, 6);
      goods = 0;
      for (int f = 0; f < nfr; f++) begin
        kind = $urandom_range(0, 3);
        n = (kind == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 10);
        if (kind == 0 && n >= 3) begin
          if (goods == LCAP) kind = 1; else goods++;
        end
        fill_rand(n);
        send_frame(n, $urandom_range(1, 3), kind, 1'($urandom_range(0, 1)));
      end
      drain(1);
    end

    // Reset mid-frame with one frame queued
    fill_rand(5); send_frame(5, 1, 0, 0);
    send_byte(8'h77, 1); send_byte(8'h88, 1);
    c0 = n_crc; a0 = n_abt; o0 = n_ovf;
    reset_n = 1'b0;
    tick();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_len", out_len, 0);
    reset_n = 1'b1;
    exp_q.delete();
    repeat (3) tick();
    chk("rst_mid_crc",   n_crc - c0, 0);
    chk("rst_mid_abort", n_abt - a0, 0);
    chk("rst_mid_ovf",   n_ovf - o0, 0);
    fill_rand(6); send_frame(6, 1, 0, 0);
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
